// File: rtl/chan_ram_fifo_ctrl.sv
// FIFO controller in front of a pipelined dual-port block RAM (3-cycle read latency).
// RAM reads return into a credit-protected skid buffer, so the output streams at one word per clock.
module chan_ram_fifo_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int SKID_DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  flush,
  input  logic                  s_valid,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  s_ready,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  input  logic                  m_ready,
  output logic                  ram_wea,
  output logic [ADDR_WIDTH-1:0] ram_addra,
  output logic [DATA_WIDTH-1:0] ram_dia,
  output logic [ADDR_WIDTH-1:0] ram_addrb,
  input  logic [DATA_WIDTH-1:0] ram_dob,
  output logic [ADDR_WIDTH+1:0] level
);
  localparam int DEPTH   = 2 ** ADDR_WIDTH;
  localparam int AW1     = ADDR_WIDTH + 1;
  localparam int LW      = ADDR_WIDTH + 2;
  localparam int SKID_AW = $clog2(SKID_DEPTH);
  localparam int CNT_W   = SKID_AW + 1;
  localparam int RD_LAT  = 4;
  localparam logic [AW1-1:0] FULL_USED = AW1'(DEPTH);
  localparam logic [CNT_W:0] SKID_FULL = (CNT_W + 1)'(SKID_DEPTH);

  logic                  r_ram_wea;
  logic [ADDR_WIDTH-1:0] r_ram_addra;
  logic [DATA_WIDTH-1:0] r_ram_dia;
  logic [ADDR_WIDTH-1:0] r_ram_addrb;
  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic [ADDR_WIDTH-1:0] r_rd_ptr;
  logic [AW1-1:0]        r_avail;
  logic [AW1-1:0]        r_ram_used;
  logic [CNT_W-1:0]      r_inflight;
  logic [RD_LAT-1:0]     r_vld_sr;
  logic [DATA_WIDTH-1:0] r_skid_mem [SKID_DEPTH];
  logic [SKID_AW-1:0]    r_skid_wp;
  logic [SKID_AW-1:0]    r_skid_rp;
  logic [CNT_W-1:0]      r_skid_cnt;
  logic [DATA_WIDTH-1:0] r_last;
  logic [LW-1:0]         r_level;

  logic                  w_accept;
  logic                  w_issue;
  logic                  w_capture;
  logic                  w_pop;
  logic [CNT_W:0]        w_credit;
  logic [DATA_WIDTH-1:0] w_head;

  assign s_ready   = resetn & (r_ram_used != FULL_USED) & ~flush;
  assign w_accept  = s_valid & s_ready;
  // Reads are issued only against committed writes and only with a free skid slot reserved.
  assign w_credit  = {1'b0, r_inflight} + {1'b0, r_skid_cnt};
  assign w_issue   = (r_avail != '0) & (w_credit < SKID_FULL);
  assign w_capture = r_vld_sr[RD_LAT-1];
  assign w_head    = r_skid_mem[r_skid_rp];
  assign m_valid   = (r_skid_cnt != '0);
  assign w_pop     = m_valid & m_ready;
  assign m_data    = m_valid ? w_head : r_last;

  assign ram_wea   = r_ram_wea;
  assign ram_addra = r_ram_addra;
  assign ram_dia   = r_ram_dia;
  assign ram_addrb = r_ram_addrb;
  assign level     = r_level;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_ram_wea   <= 1'b0;
      r_ram_addra <= '0;
      r_ram_dia   <= '0;
      r_ram_addrb <= '0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_avail     <= '0;
      r_ram_used  <= '0;
      r_inflight  <= '0;
      r_vld_sr    <= '0;
      r_skid_wp   <= '0;
      r_skid_rp   <= '0;
      r_skid_cnt  <= '0;
      r_last      <= '0;
      r_level     <= '0;
    end else if (flush) begin
      r_ram_wea  <= 1'b0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_avail    <= '0;
      r_ram_used <= '0;
      r_inflight <= '0;
      r_vld_sr   <= '0;
      r_skid_wp  <= '0;
      r_skid_rp  <= '0;
      r_skid_cnt <= '0;
      r_level    <= '0;
    end else begin
      r_ram_wea <= w_accept;
      if (w_accept) begin
        r_ram_addra <= r_wr_ptr;
        r_ram_dia   <= s_data;
        r_wr_ptr    <= r_wr_ptr + ADDR_WIDTH'(1);
      end
      if (w_issue) begin
        r_ram_addrb <= r_rd_ptr;
        r_rd_ptr    <= r_rd_ptr + ADDR_WIDTH'(1);
      end
      r_vld_sr   <= {r_vld_sr[RD_LAT-2:0], w_issue};
      r_avail    <= r_avail + AW1'(r_ram_wea) - AW1'(w_issue);
      r_ram_used <= r_ram_used + AW1'(w_accept) - AW1'(w_issue);
      r_inflight <= r_inflight + CNT_W'(w_issue) - CNT_W'(w_capture);
      if (w_capture) r_skid_wp <= r_skid_wp + SKID_AW'(1);
      if (w_pop) begin
        r_skid_rp <= r_skid_rp + SKID_AW'(1);
        r_last    <= w_head;
      end
      r_skid_cnt <= r_skid_cnt + CNT_W'(w_capture) - CNT_W'(w_pop);
      r_level    <= r_level + LW'(w_accept) - LW'(w_pop);
    end
  end

  // NOTE: skid storage is not reset; an entry is only read after a capture has written it.
  always_ff @(posedge clk) begin
    if (w_capture) r_skid_mem[r_skid_wp] <= ram_dob;
  end

endmodule

// File: tb/tb_chan_ram_fifo_ctrl.sv
// Self-checking bench for chan_ram_fifo_ctrl: latency vector table, queue-model scoreboard
// under streaming/full/random traffic, and hand-written flush and async-reset sequences.
module tb_chan_ram_fifo_ctrl;
  localparam int DW = 32;
  localparam int AW = 8;
  localparam int SD = 8;
  localparam int DEPTH = 2 ** AW;

  logic          clk = 1'b0;
  logic          resetn;
  logic          flush;
  logic          s_valid;
  logic [DW-1:0] s_data;
  logic          s_ready;
  logic          m_valid;
  logic [DW-1:0] m_data;
  logic          m_ready;
  logic          ram_wea;
  logic [AW-1:0] ram_addra;
  logic [DW-1:0] ram_dia;
  logic [AW-1:0] ram_addrb;
  logic [DW-1:0] ram_dob;
  logic [AW+1:0] level;

  chan_ram_fifo_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SKID_DEPTH(SD)) dut (
    .clk(clk), .resetn(resetn), .flush(flush),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready),
    .ram_wea(ram_wea), .ram_addra(ram_addra), .ram_dia(ram_dia),
    .ram_addrb(ram_addrb), .ram_dob(ram_dob), .level(level)
  );

  always #5 clk = ~clk;

  // Write-first dual-port RAM, data 3 cycles after the read address.
  logic [DW-1:0] ram [DEPTH];
  logic [DW-1:0] rd_p1, rd_p2;
  always @(posedge clk) begin
    if (ram_wea) ram[ram_addra] <= ram_dia;
    rd_p1   <= (ram_wea && ram_addra == ram_addrb) ? ram_dia : ram[ram_addrb];
    rd_p2   <= rd_p1;
    ram_dob <= rd_p2;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic          sv;
    logic [DW-1:0] sd;
    logic          exp_wea;
    logic [AW-1:0] exp_addra;
    logic [DW-1:0] exp_dia;
    logic [AW-1:0] exp_addrb;
    logic          exp_mv;
    logic [DW-1:0] exp_md;
    logic [AW+1:0] exp_lvl;
  } vec_t;

  vec_t vecs[$];

  function automatic void add_vec(input logic sv, input logic [DW-1:0] sd, input logic wea,
                                  input logic [AW-1:0] addra, input logic [DW-1:0] dia,
                                  input logic [AW-1:0] addrb, input logic mv,
                                  input logic [DW-1:0] md, input logic [AW+1:0] lvl);
    vec_t v;
    v.sv = sv; v.sd = sd; v.exp_wea = wea; v.exp_addra = addra; v.exp_dia = dia;
    v.exp_addrb = addrb; v.exp_mv = mv; v.exp_md = md; v.exp_lvl = lvl;
    vecs.push_back(v);
  endfunction

  // Scoreboard: the FIFO contents are exactly the accepted-but-not-popped words.
  logic [DW-1:0] q[$];

  task automatic run_cycle(input logic sv, input logic [DW-1:0] sd, input logic mr,
                           output logic acc, output logic pop);
    logic [DW-1:0] exp;
    s_valid = sv;
    s_data  = sd;
    m_ready = mr;
    @(negedge clk);
    acc = s_valid & s_ready;
    pop = m_valid & m_ready;
    check("level_vs_model", 64'(level), 64'(q.size()));
    if (pop) begin
      if (q.size() == 0) check("pop_with_empty_model", 64'(m_valid), 64'(0));
      else begin
        exp = q.pop_front();
        check("m_data_order", 64'(m_data), 64'(exp));
      end
    end
    if (acc) q.push_back(sd);
    @(posedge clk); #1;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  logic acc, pop;
  int sent, got, cyc, first_acc, first_out, gaps, bad;

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    resetn = 1'b0; flush = 1'b0; s_valid = 1'b0; s_data = '0; m_ready = 1'b1;

    // Reset values while resetn is low
    #12;
    check("rst_s_ready", 64'(s_ready), 64'(0));
    check("rst_m_valid", 64'(m_valid), 64'(0));
    check("rst_m_data", 64'(m_data), 64'(0));
    check("rst_ram_wea", 64'(ram_wea), 64'(0));
    check("rst_ram_addra", 64'(ram_addra), 64'(0));
    check("rst_ram_dia", 64'(ram_dia), 64'(0));
    check("rst_ram_addrb", 64'(ram_addrb), 64'(0));
    check("rst_level", 64'(level), 64'(0));
    tick(); tick();
    resetn = 1'b1;

    // Single-word latency table: A accepted at cycle 0, B at cycle 9
    add_vec(1, 32'hA5A5A5A5, 0, 0, 0, 0, 0, 0, 0);
    add_vec(0, 0, 1, 0, 32'hA5A5A5A5, 0, 0, 0, 1);
    for (int c = 2; c <= 6; c++) add_vec(0, 0, 0, 0, 0, 0, 0, 0, 1);
    add_vec(0, 0, 0, 0, 0, 0, 1, 32'hA5A5A5A5, 1);
    add_vec(0, 0, 0, 0, 0, 0, 0, 0, 0);
    add_vec(1, 32'h5A5A5A5A, 0, 0, 0, 0, 0, 0, 0);
    add_vec(0, 0, 1, 1, 32'h5A5A5A5A, 0, 0, 0, 1);
    add_vec(0, 0, 0, 1, 0, 0, 0, 0, 1);
    for (int c = 12; c <= 15; c++) add_vec(0, 0, 0, 1, 0, 1, 0, 0, 1);
    add_vec(0, 0, 0, 1, 0, 1, 1, 32'h5A5A5A5A, 1);
    add_vec(0, 0, 0, 1, 0, 1, 0, 0, 0);

    foreach (vecs[i]) begin
      s_valid = vecs[i].sv; s_data = vecs[i].sd; m_ready = 1'b1;
      @(negedge clk);
      check($sformatf("vec%0d_s_ready", i), 64'(s_ready), 64'(1));
      check($sformatf("vec%0d_ram_wea", i), 64'(ram_wea), 64'(vecs[i].exp_wea));
      check($sformatf("vec%0d_ram_addra", i), 64'(ram_addra), 64'(vecs[i].exp_addra));
      if (vecs[i].exp_wea) check($sformatf("vec%0d_ram_dia", i), 64'(ram_dia), 64'(vecs[i].exp_dia));
      check($sformatf("vec%0d_ram_addrb", i), 64'(ram_addrb), 64'(vecs[i].exp_addrb));
      check($sformatf("vec%0d_m_valid", i), 64'(m_valid), 64'(vecs[i].exp_mv));
      if (vecs[i].exp_mv) check($sformatf("vec%0d_m_data", i), 64'(m_data), 64'(vecs[i].exp_md));
      check($sformatf("vec%0d_level", i), 64'(level), 64'(vecs[i].exp_lvl));
      tick();
    end
    s_valid = 1'b0;

    // 1000-word stream at full rate
    sent = 0; got = 0; cyc = 0; first_acc = -1; first_out = -1; gaps = 0;
    while (got < 1000 && cyc < 1300) begin
      run_cycle(sent < 1000, 32'(sent), 1'b1, acc, pop);
      if (acc) begin
        if (first_acc < 0) first_acc = cyc;
        sent++;
      end
      if (pop) begin
        if (first_out < 0) first_out = cyc;
        got++;
      end else if (first_out >= 0 && got < 1000) gaps++;
      cyc++;
    end
    check("stream_words_out", 64'(got), 64'(1000));
    check("stream_gap_cycles", 64'(gaps), 64'(0));
    check("stream_fill_latency", 64'(first_out - first_acc), 64'(7));

    // Fill with m_ready low, then drain
    sent = 0;
    for (int i = 0; i < 300; i++) begin
      run_cycle(1'b1, 32'h1000_0000 + 32'(sent), 1'b0, acc, pop);
      if (acc) sent++;
    end
    check("full_accepted", 64'(sent), 64'(DEPTH + SD));
    s_valid = 1'b0;
    @(negedge clk);
    check("full_s_ready", 64'(s_ready), 64'(0));
    check("full_level", 64'(level), 64'(DEPTH + SD));
    tick();
    got = 0; cyc = 0;
    while (got < DEPTH + SD && cyc < 600) begin
      run_cycle(1'b0, '0, 1'b1, acc, pop);
      if (pop) got++;
      cyc++;
    end
    check("drain_words_out", 64'(got), 64'(DEPTH + SD));
    @(negedge clk);
    check("drain_s_ready", 64'(s_ready), 64'(1));
    check("drain_m_valid", 64'(m_valid), 64'(0));
    tick();

    // Random traffic across several pointer wraps
    sent = 0; got = 0; cyc = 0;
    while ((sent < 3 * DEPTH || q.size() > 0) && cyc < 8000) begin
      run_cycle((sent < 3 * DEPTH) && ($urandom_range(1, 0) == 1), $urandom(),
                $urandom_range(1, 0) == 1, acc, pop);
      if (acc) sent++;
      if (pop) got++;
      cyc++;
    end
    check("random_words_out", 64'(got), 64'(3 * DEPTH));
    for (int i = 0; i < 12; i++) run_cycle(1'b0, '0, 1'b1, acc, pop);

    // Flush with reads in flight and words in the skid buffer
    sent = 0;
    for (int i = 0; i < 11; i++) begin
      run_cycle(1'b1, 32'hF000_0000 + 32'(i), 1'b0, acc, pop);
      if (acc) sent++;
    end
    check("preflush_accepted", 64'(sent), 64'(11));
    flush = 1'b1; s_valid = 1'b1; s_data = 32'hDEAD_BEEF; m_ready = 1'b0;
    @(negedge clk);
    check("flush_s_ready", 64'(s_ready), 64'(0));
    check("preflush_level", 64'(level), 64'(11));
    tick();
    flush = 1'b0; q.delete();
    s_valid = 1'b1; s_data = 32'h0000_1234; m_ready = 1'b1;
    @(negedge clk);
    check("postflush_level", 64'(level), 64'(0));
    check("postflush_m_valid", 64'(m_valid), 64'(0));
    check("postflush_s_ready", 64'(s_ready), 64'(1));
    tick();
    s_valid = 1'b0;
    bad = 0;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (m_valid) bad++;
      tick();
    end
    check("postflush_stale_words", 64'(bad), 64'(0));
    @(negedge clk);
    check("postflush_word_valid", 64'(m_valid), 64'(1));
    check("postflush_word_data", 64'(m_data), 64'(32'h0000_1234));
    tick();
    @(negedge clk);
    check("postflush_single_word", 64'(m_valid), 64'(0));
    check("postflush_final_level", 64'(level), 64'(0));
    tick();

    // Asynchronous reset mid-stream
    for (int i = 0; i < 20; i++) run_cycle(1'b1, 32'h7700_0000 + 32'(i), 1'b1, acc, pop);
    #1 resetn = 1'b0;
    #1;
    check("arst_s_ready", 64'(s_ready), 64'(0));
    check("arst_m_valid", 64'(m_valid), 64'(0));
    check("arst_m_data", 64'(m_data), 64'(0));
    check("arst_ram_wea", 64'(ram_wea), 64'(0));
    check("arst_ram_addra", 64'(ram_addra), 64'(0));
    check("arst_ram_dia", 64'(ram_dia), 64'(0));
    check("arst_ram_addrb", 64'(ram_addrb), 64'(0));
    check("arst_level", 64'(level), 64'(0));
    s_valid = 1'b0;
    tick(); tick();
    resetn = 1'b1; q.delete();
    s_valid = 1'b1; s_data = 32'hCAFE_F00D; m_ready = 1'b1;
    @(negedge clk);
    check("after_rst_accept", 64'(s_ready), 64'(1));
    tick();
    s_valid = 1'b0;
    bad = 0;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (m_valid) bad++;
      tick();
    end
    check("after_rst_early_valid", 64'(bad), 64'(0));
    @(negedge clk);
    check("after_rst_word_valid", 64'(m_valid), 64'(1));
    check("after_rst_word_data", 64'(m_data), 64'(32'hCAFE_F00D));
    check("after_rst_level", 64'(level), 64'(1));
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
